// File: rtl/vending_ctrl.sv
// vending_ctrl
//   Coin-acceptor / vending controller. Three coin denominations, a
//   programmable price, a credit ceiling and carry-over of excess credit.
//   The dispense command is held until the product mechanism acknowledges.
//
//   Optional feature macro: VEND_CHANGE_EN
//     defined   : excess credit after a vend, or the whole credit on a cancel
//                 in COLLECT, is paid out as a one-cycle change pulse.
//     undefined : no change path; cancel_in ignored; excess credit carries over.
//
// Ports
//   clock             in   posedge clock
//   reset             in   synchronous, active-high reset
//   coin_a_in         in   one-cycle pulse, COIN_A inserted
//   coin_b_in         in   one-cycle pulse, COIN_B inserted
//   coin_c_in         in   one-cycle pulse, COIN_C inserted
//   cancel_in         in   refund request
//   dispense_ack_in   in   mechanism has delivered the product
//   open_out          out  dispense command
//   credit_out        out  current credit
//   coin_reject_out   out  one-cycle pulse, coin returned uncredited
//   change_valid_out  out  one-cycle pulse, change_out valid
//   change_out        out  amount returned, 0 when change_valid_out is low

module vending_ctrl #(
  parameter int unsigned CREDIT_W   = 8,
  parameter int unsigned COIN_A     = 10,
  parameter int unsigned COIN_B     = 20,
  parameter int unsigned COIN_C     = 50,
  parameter int unsigned PRICE      = 30,
  parameter int unsigned MAX_CREDIT = 200
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                coin_a_in,
  input  logic                coin_b_in,
  input  logic                coin_c_in,
  input  logic                cancel_in,
  input  logic                dispense_ack_in,
  output logic                open_out,
  output logic [CREDIT_W-1:0] credit_out,
  output logic                coin_reject_out,
  output logic                change_valid_out,
  output logic [CREDIT_W-1:0] change_out
);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DISPENSE,
    CHANGE
  } state_t;

  localparam logic [CREDIT_W:0]   LP_COIN_A  = (CREDIT_W+1)'(COIN_A);
  localparam logic [CREDIT_W:0]   LP_COIN_B  = (CREDIT_W+1)'(COIN_B);
  localparam logic [CREDIT_W:0]   LP_COIN_C  = (CREDIT_W+1)'(COIN_C);
  localparam logic [CREDIT_W:0]   LP_MAX     = (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [CREDIT_W:0]   LP_PRICE_X = (CREDIT_W+1)'(PRICE);
  localparam logic [CREDIT_W-1:0] LP_PRICE   = CREDIT_W'(PRICE);

  state_t              r_state;
  logic [CREDIT_W-1:0] r_credit;
  logic                r_open;
  logic                r_reject;

  logic [1:0]          w_coin_cnt;
  logic                w_any_coin;
  logic [CREDIT_W:0]   w_coin_val;
  logic [CREDIT_W:0]   w_sum;
  logic                w_collecting;
  logic                w_cancel;
  logic                w_accept;
  logic [CREDIT_W-1:0] w_remain;

  assign w_coin_cnt   = {1'b0, coin_a_in} + {1'b0, coin_b_in} + {1'b0, coin_c_in};
  assign w_any_coin   = coin_a_in | coin_b_in | coin_c_in;
  assign w_collecting = (r_state == IDLE) || (r_state == COLLECT);

  always_comb begin
    w_coin_val = '0;
    if (coin_a_in)      w_coin_val = LP_COIN_A;
    else if (coin_b_in) w_coin_val = LP_COIN_B;
    else if (coin_c_in) w_coin_val = LP_COIN_C;
  end

  // One bit wider than the credit register so an overflowing sum is seen
  // and rejected instead of wrapping.
  assign w_sum    = {1'b0, r_credit} + w_coin_val;
  assign w_remain = r_credit - LP_PRICE;

`ifdef VEND_CHANGE_EN
  logic                r_change_valid;
  logic [CREDIT_W-1:0] r_change;

  assign w_cancel = cancel_in && (r_state == COLLECT);
`else
  logic w_unused_cancel;

  assign w_unused_cancel = cancel_in;
  assign w_cancel        = 1'b0;
`endif

  // A refund in progress takes priority over any coin in the same cycle.
  assign w_accept = w_collecting && (w_coin_cnt == 2'd1) && !w_cancel &&
                    (w_sum <= LP_MAX);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= IDLE;
      r_credit <= '0;
      r_open   <= 1'b0;
      r_reject <= 1'b0;
`ifdef VEND_CHANGE_EN
      r_change_valid <= 1'b0;
      r_change       <= '0;
`endif
    end else begin
      r_reject <= w_any_coin && !w_accept;
`ifdef VEND_CHANGE_EN
      r_change_valid <= 1'b0;
      r_change       <= '0;
`endif
      unique case (r_state)
        IDLE, COLLECT: begin
          if (w_cancel) begin
`ifdef VEND_CHANGE_EN
            r_state        <= CHANGE;
            r_change_valid <= 1'b1;
            r_change       <= r_credit;
`endif
          end else if (w_accept) begin
            r_credit <= w_sum[CREDIT_W-1:0];
            if (w_sum >= LP_PRICE_X) begin
              r_state <= DISPENSE;
              r_open  <= 1'b1;
            end else begin
              r_state <= COLLECT;
            end
          end
        end

        // open_out is a flag rather than a state decode so that a back-to-back
        // vend from carried-over credit can drop the command for one cycle
        // while staying in DISPENSE; an ack during that gap is not counted.
        DISPENSE: begin
          if (!r_open) begin
            r_open <= 1'b1;
          end else if (dispense_ack_in) begin
            r_credit <= w_remain;
            r_open   <= 1'b0;
`ifdef VEND_CHANGE_EN
            if (w_remain != '0) begin
              r_state        <= CHANGE;
              r_change_valid <= 1'b1;
              r_change       <= w_remain;
            end else begin
              r_state <= IDLE;
            end
`else
            if (w_remain >= LP_PRICE) begin
              r_state <= DISPENSE;
            end else if (w_remain != '0) begin
              r_state <= COLLECT;
            end else begin
              r_state <= IDLE;
            end
`endif
          end
        end

        CHANGE: begin
          r_credit <= '0;
          r_state  <= IDLE;
        end

        default: begin
          r_state  <= IDLE;
          r_credit <= '0;
          r_open   <= 1'b0;
        end
      endcase
    end
  end

  assign open_out        = r_open;
  assign credit_out      = r_credit;
  assign coin_reject_out = r_reject;

`ifdef VEND_CHANGE_EN
  assign change_valid_out = r_change_valid;
  assign change_out       = r_change;
`else
  assign change_valid_out = 1'b0;
  assign change_out       = '0;
`endif

endmodule

// File: tb/tb_vending_ctrl.sv
// tb_vending_ctrl
//   Self-checking bench for vending_ctrl. Directed scenarios followed by a
//   randomized run, all compared cycle by cycle against a purchase-level
//   reference model. A second instance with a high price exercises the credit
//   ceiling with hand-derived constants.

module tb_vending_ctrl;

  localparam int P_W     = 8;
  localparam int P_A     = 10;
  localparam int P_B     = 20;
  localparam int P_C     = 50;
  localparam int P_PRICE = 30;
  localparam int P_MAX   = 200;

  logic           clock;
  logic           reset;
  logic           coin_a, coin_b, coin_c, cancel, ack;
  logic           open_o, reject_o, chg_v_o;
  logic [P_W-1:0] credit_o, chg_o;

  logic           t2_a, t2_b, t2_c, t2_cancel, t2_ack;
  logic           t2_open, t2_reject, t2_chg_v;
  logic [P_W-1:0] t2_credit, t2_chg;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int m_credit;
  bit m_wait_ack;
  bit m_gap;
  bit m_refund;
  int e_open, e_credit, e_reject, e_chg_v, e_chg;

  vending_ctrl #(
    .CREDIT_W(P_W), .COIN_A(P_A), .COIN_B(P_B), .COIN_C(P_C),
    .PRICE(P_PRICE), .MAX_CREDIT(P_MAX)
  ) dut (
    .clock(clock), .reset(reset),
    .coin_a_in(coin_a), .coin_b_in(coin_b), .coin_c_in(coin_c),
    .cancel_in(cancel), .dispense_ack_in(ack),
    .open_out(open_o), .credit_out(credit_o), .coin_reject_out(reject_o),
    .change_valid_out(chg_v_o), .change_out(chg_o)
  );

  vending_ctrl #(
    .CREDIT_W(P_W), .COIN_A(P_A), .COIN_B(P_B), .COIN_C(P_C),
    .PRICE(200), .MAX_CREDIT(200)
  ) dut_sat (
    .clock(clock), .reset(reset),
    .coin_a_in(t2_a), .coin_b_in(t2_b), .coin_c_in(t2_c),
    .cancel_in(t2_cancel), .dispense_ack_in(t2_ack),
    .open_out(t2_open), .credit_out(t2_credit), .coin_reject_out(t2_reject),
    .change_valid_out(t2_chg_v), .change_out(t2_chg)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d, required %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_credit = 0; m_wait_ack = 0; m_gap = 0; m_refund = 0;
    e_open = 0; e_credit = 0; e_reject = 0; e_chg_v = 0; e_chg = 0;
  endtask

  // One clock of customer/mechanism activity, described in purchase terms.
  task automatic model_step(input bit a, input bit b, input bit c, input bit cn, input bit ak);
    int n, v;
    n = int'(a) + int'(b) + int'(c);
    v = (a ? P_A : 0) + (b ? P_B : 0) + (c ? P_C : 0);
    e_reject = 0; e_chg_v = 0; e_chg = 0;
    if (m_refund) begin
      m_credit = 0;
      m_refund = 0;
      e_reject = (n != 0) ? 1 : 0;
    end else if (m_wait_ack || m_gap) begin
      e_reject = (n != 0) ? 1 : 0;
      if (m_gap) begin
        m_gap = 0;
        m_wait_ack = 1;
      end else if (ak) begin
        m_credit = m_credit - P_PRICE;
        m_wait_ack = 0;
`ifdef VEND_CHANGE_EN
        if (m_credit > 0) begin
          m_refund = 1; e_chg_v = 1; e_chg = m_credit;
        end
`else
        if (m_credit >= P_PRICE) m_gap = 1;
`endif
      end
    end else begin
`ifdef VEND_CHANGE_EN
      if (cn && m_credit > 0) begin
        m_refund = 1; e_chg_v = 1; e_chg = m_credit;
        e_reject = (n != 0) ? 1 : 0;
      end else
`endif
      if (n == 1 && m_credit + v <= P_MAX) begin
        m_credit = m_credit + v;
        if (m_credit >= P_PRICE) m_wait_ack = 1;
      end else begin
        e_reject = (n != 0) ? 1 : 0;
      end
    end
    if (cn && !ak && n > 3) e_reject = 0;
    e_open   = m_wait_ack ? 1 : 0;
    e_credit = m_credit;
  endtask

  task automatic cyc(input bit a, input bit b, input bit c, input bit cn, input bit ak,
                     input string tag);
    @(negedge clock);
    coin_a = a; coin_b = b; coin_c = c; cancel = cn; ack = ak;
    model_step(a, b, c, cn, ak);
    @(posedge clock);
    #1;
    chk({tag, ".open"},   32'(open_o),   32'(e_open));
    chk({tag, ".credit"}, 32'(credit_o), 32'(e_credit));
    chk({tag, ".reject"}, 32'(reject_o), 32'(e_reject));
    chk({tag, ".chg_v"},  32'(chg_v_o),  32'(e_chg_v));
    chk({tag, ".chg"},    32'(chg_o),    32'(e_chg));
  endtask

  task automatic t2_cyc(input bit a, input bit b, input bit c, input bit ak,
                        input int x_open, input int x_credit, input int x_reject,
                        input string tag);
    @(negedge clock);
    t2_a = a; t2_b = b; t2_c = c; t2_ack = ak;
    @(posedge clock);
    #1;
    chk({tag, ".open"},   32'(t2_open),   32'(x_open));
    chk({tag, ".credit"}, 32'(t2_credit), 32'(x_credit));
    chk({tag, ".reject"}, 32'(t2_reject), 32'(x_reject));
    chk({tag, ".chg_v"},  32'(t2_chg_v),  32'd0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clock);
    reset = 1'b1;
    coin_a = 0; coin_b = 0; coin_c = 0; cancel = 0; ack = 0;
    t2_a = 0; t2_b = 0; t2_c = 0; t2_cancel = 0; t2_ack = 0;
    @(posedge clock);
    #1;
    model_reset();
    chk({tag, ".open"},   32'(open_o),   32'd0);
    chk({tag, ".credit"}, 32'(credit_o), 32'd0);
    chk({tag, ".reject"}, 32'(reject_o), 32'd0);
    chk({tag, ".chg_v"},  32'(chg_v_o),  32'd0);
    chk({tag, ".chg"},    32'(chg_o),    32'd0);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    coin_a = 0; coin_b = 0; coin_c = 0; cancel = 0; ack = 0;
    t2_a = 0; t2_b = 0; t2_c = 0; t2_cancel = 0; t2_ack = 0;
    model_reset();
    do_reset("rst0");

    // credit ceiling on the PRICE=200 instance
    t2_cyc(0, 0, 1, 0, 0,  50, 0, "sat_c1");
    t2_cyc(0, 0, 1, 0, 0, 100, 0, "sat_c2");
    t2_cyc(0, 0, 1, 0, 0, 150, 0, "sat_c3");
    t2_cyc(1, 0, 0, 0, 0, 160, 0, "sat_a1");
    t2_cyc(1, 0, 0, 0, 0, 170, 0, "sat_a2");
    t2_cyc(1, 0, 0, 0, 0, 180, 0, "sat_a3");
    t2_cyc(0, 0, 1, 0, 0, 180, 1, "sat_over");
    t2_cyc(0, 0, 0, 0, 0, 180, 0, "sat_idle");
    t2_cyc(0, 1, 0, 0, 1, 200, 0, "sat_exact");
    t2_cyc(1, 0, 0, 0, 1, 200, 1, "sat_a_in_disp");
    t2_cyc(0, 0, 0, 1, 0,   0, 0, "sat_ack");
    t2_cyc(0, 0, 0, 0, 0,   0, 0, "sat_done");

    // three small coins then acknowledge
    do_reset("rst1");
    cyc(1, 0, 0, 0, 0, "a1");
    chk("a1.const", 32'(credit_o), 32'd10);
    cyc(1, 0, 0, 0, 0, "a2");
    chk("a2.const", 32'(credit_o), 32'd20);
    cyc(1, 0, 0, 0, 0, "a3");
    chk("a3.const", 32'(credit_o), 32'd30);
    chk("a3.open_const", 32'(open_o), 32'd1);
    cyc(0, 0, 0, 0, 1, "ack1");
    chk("ack1.const", 32'(credit_o), 32'd0);

    // two coins in one cycle
    cyc(1, 1, 0, 0, 0, "dbl");
    chk("dbl.rej_const", 32'(reject_o), 32'd1);
    cyc(0, 0, 0, 0, 0, "dbl_after");

    // large coin, long wait for ack, coin during the wait, coin with ack
    cyc(0, 0, 1, 0, 0, "c1");
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, "wait");
    chk("wait.open_const", 32'(open_o), 32'd1);
    cyc(1, 0, 0, 0, 0, "a_mid");
    cyc(0, 0, 0, 0, 0, "a_mid_after");
    cyc(1, 0, 0, 0, 1, "ack_coin");
    cyc(0, 0, 0, 0, 0, "post_ack");

    // carried-over credit large enough for a second vend
    do_reset("rst2");
    cyc(0, 1, 0, 0, 0, "b1");
    cyc(0, 0, 1, 0, 0, "c70");
    cyc(0, 0, 0, 0, 1, "ack70");
    cyc(0, 0, 0, 0, 1, "gap_ack");
    cyc(0, 0, 0, 0, 1, "ack40");
    cyc(0, 0, 0, 0, 0, "after40");

    // cancel with partial credit
    do_reset("rst3");
    cyc(0, 1, 0, 0, 0, "b_cancel");
    cyc(0, 0, 0, 1, 0, "cancel");
    cyc(0, 0, 0, 0, 0, "cancel_after");
    cyc(1, 0, 0, 1, 0, "cancel_coin");
    cyc(0, 0, 0, 0, 0, "cancel_coin_after");

    // reset while the dispense command is active
    do_reset("rst4");
    cyc(0, 0, 1, 0, 0, "c_pre_rst");
    chk("pre_rst.open_const", 32'(open_o), 32'd1);
    do_reset("rst_mid");
    cyc(0, 0, 0, 0, 0, "post_rst");

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int r;
      bit a, b, c, cn, ak;
      r = int'($urandom_range(0, 99));
      a = 0; b = 0; c = 0;
      if (r < 50) begin
      end else if (r < 65) a = 1;
      else if (r < 78) b = 1;
      else if (r < 90) c = 1;
      else begin
        a = 1'($urandom_range(0, 1));
        b = 1'($urandom_range(0, 1));
        c = 1;
      end
      ak = ($urandom_range(0, 99) < 35);
      cn = ($urandom_range(0, 99) < 8);
      cyc(a, b, c, cn, ak, "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
